// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 2-flop synchroniser, false-start rejection, optional parity,
// 1 or 2 stop bits, and a valid/ready holding register with overrun reporting.
module uart_rx_frame #(
    parameter int CLK_F     = 50_000_000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] uart_data_out,
    output logic                 uart_valid,
    input  logic                 uart_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CLK_GOAL = CLK_F / UART_BPS;
    localparam int CNT_W    = (CLK_GOAL > 1) ? $clog2(CLK_GOAL) : 1;
    localparam logic [CNT_W-1:0] MID       = CNT_W'(CLK_GOAL / 2);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLK_GOAL - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (CLK_GOAL < 4) begin : g_bad_goal
            $error("uart_rx_frame: CLK_F / UART_BPS must be >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
            $error("uart_rx_frame: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_rx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_rx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic                 prev_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [3:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 ferr_q;

    logic rxd_s, start_edge_d, sample_d, bit_end_d, perr_d;

    assign rxd_s        = sync_q[1];
    assign start_edge_d = prev_q & ~rxd_s;
    assign sample_d     = (cnt_q == MID);
    assign bit_end_d    = (cnt_q == LAST);

    always_comb begin
        perr_d = 1'b0;
        if (PARITY == 1)
            perr_d = ~(^shift_q ^ par_q);
        else if (PARITY == 2)
            perr_d = ^shift_q ^ par_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sync_q        <= 2'b11;
            prev_q        <= 1'b1;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            ferr_q        <= 1'b0;
            uart_data_out <= '0;
            uart_valid    <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], uart_rxd};
            prev_q  <= rxd_s;
            overrun <= 1'b0;
            cnt_q   <= (state_q == S_IDLE || bit_end_d) ? '0 : cnt_q + 1'b1;
            // Acceptance; a completing frame below overrides this with a fresh load.
            if (uart_valid && uart_ready)
                uart_valid <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_edge_d) begin
                        state_q <= S_START;
                        idx_q   <= '0;
                        ferr_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (sample_d && rxd_s)
                        state_q <= S_IDLE;
                    else if (bit_end_d)
                        state_q <= S_DATA;
                end
                S_DATA: begin
                    // LSB arrives first, so after DATA_BITS right-shifts it sits at bit 0.
                    if (sample_d)
                        shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (bit_end_d) begin
                        if (idx_q == LAST_DATA) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (sample_d)
                        par_q <= rxd_s;
                    if (bit_end_d)
                        state_q <= S_STOP;
                end
                S_STOP: begin
                    if (sample_d && idx_q == LAST_STOP) begin
                        state_q <= S_IDLE;
                        if (!uart_valid || uart_ready) begin
                            uart_data_out <= shift_q;
                            parity_err    <= perr_d;
                            frame_err     <= ferr_q | ~rxd_s;
                            uart_valid    <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        if (sample_d && !rxd_s)
                            ferr_q <= 1'b1;
                        if (bit_end_d)
                            idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three configurations (8N1, 8E1, 7O2) driven with directed and
// random frames; expected words and flags come from a frame-level model.
module tb_uart_rx_frame;
    localparam int BIT_CLKS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic rxd_a = 1'b1, rxd_e = 1'b1, rxd_c = 1'b1;
    logic rdy_a = 1'b0, rdy_e = 1'b0, rdy_c = 1'b0;
    logic [7:0] data_a, data_e;
    logic [6:0] data_c;
    logic vld_a, vld_e, vld_c, perr_a, perr_e, perr_c;
    logic ferr_a, ferr_e, ferr_c, ovr_a, ovr_e, ovr_c;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt_a = 0, ovr_cnt_e = 0, ovr_cnt_c = 0;

    uart_rx_frame #(.CLK_F(1_600_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .uart_rxd(rxd_a), .uart_data_out(data_a), .uart_valid(vld_a),
        .uart_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a));
    uart_rx_frame #(.CLK_F(1_600_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst(rst), .uart_rxd(rxd_e), .uart_data_out(data_e), .uart_valid(vld_e),
        .uart_ready(rdy_e), .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e));
    uart_rx_frame #(.CLK_F(1_600_000), .UART_BPS(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .uart_rxd(rxd_c), .uart_data_out(data_c), .uart_valid(vld_c),
        .uart_ready(rdy_c), .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c));

    always @(negedge clk) if (ovr_a === 1'b1) ovr_cnt_a++;
    always @(negedge clk) if (ovr_e === 1'b1) ovr_cnt_e++;
    always @(negedge clk) if (ovr_c === 1'b1) ovr_cnt_c++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame-level model: parity error from the count of ones over data plus parity bit.
    function automatic bit model_perr(input int pmode, input int data, input int nbits, input bit p);
        int ones;
        if (pmode == 0) return 1'b0;
        ones = $countones(data & ((1 << nbits) - 1)) + int'(p);
        if (pmode == 2) return (ones % 2) != 0;
        return (ones % 2) == 0;
    endfunction

    function automatic logic [8:0] get_data(input int d);
        case (d)
            0:       return {1'b0, data_a};
            1:       return {1'b0, data_e};
            default: return {2'b0, data_c};
        endcase
    endfunction

    // {valid, parity_err, frame_err, overrun}
    function automatic logic [3:0] get_flags(input int d);
        case (d)
            0:       return {vld_a, perr_a, ferr_a, ovr_a};
            1:       return {vld_e, perr_e, ferr_e, ovr_e};
            default: return {vld_c, perr_c, ferr_c, ovr_c};
        endcase
    endfunction

    function automatic int get_ovr_cnt(input int d);
        case (d)
            0:       return ovr_cnt_a;
            1:       return ovr_cnt_e;
            default: return ovr_cnt_c;
        endcase
    endfunction

    task automatic hold_line(input int d, input logic v, input int n);
        #1;
        case (d)
            0:       rxd_a = v;
            1:       rxd_e = v;
            default: rxd_c = v;
        endcase
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input int d, input int data, input int nbits, input int pmode,
                              input bit p, input int nstop, input logic stopval);
        logic [15:0] bits;
        int n;
        n = 0;
        bits = '0;
        for (int i = 0; i < nbits; i++) begin
            bits[n] = logic'((data >> i) & 1);
            n++;
        end
        if (pmode != 0) begin
            bits[n] = p;
            n++;
        end
        hold_line(d, 1'b0, BIT_CLKS);
        for (int i = 0; i < n; i++) hold_line(d, bits[i], BIT_CLKS);
        for (int i = 0; i < nstop; i++) hold_line(d, stopval, BIT_CLKS);
    endtask

    task automatic wait_valid(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (get_flags(d)[3] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic accept(input int d);
        @(posedge clk);
        #1;
        case (d)
            0: rdy_a = 1'b1;
            1: rdy_e = 1'b1;
            default: rdy_c = 1'b1;
        endcase
        @(posedge clk);
        #1;
        rdy_a = 1'b0;
        rdy_e = 1'b0;
        rdy_c = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (get_data(d) !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_data dut%0d: got %h want 0", d, get_data(d));
            end
            n_checks++;
            if (get_flags(d) !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_flags dut%0d: got %b want 0000", d, get_flags(d));
            end
        end
    endtask

    task automatic test_basic;
        bit ok;
        send_frame(0, 8'hA5, 8, 0, 1'b0, 1, 1'b1);
        wait_valid(0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_valid: timeout, want valid=1"); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (get_data(0) !== 9'h0A5) begin
            n_fail++; $display("FAIL basic_data: got %h want 0a5", get_data(0));
        end
        n_checks++;
        if (get_flags(0) !== 4'b1000) begin
            n_fail++; $display("FAIL basic_flags held: got %b want 1000", get_flags(0));
        end
        accept(0);
        @(negedge clk);
        n_checks++;
        if (vld_a !== 1'b0) begin
            n_fail++; $display("FAIL basic_accept: valid got %b want 0", vld_a);
        end
    endtask

    task automatic test_glitch;
        bit ok;
        int ovr0;
        ovr0 = get_ovr_cnt(0);
        hold_line(0, 1'b0, 4);
        hold_line(0, 1'b1, 3 * BIT_CLKS);
        @(negedge clk);
        n_checks++;
        if (vld_a !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", vld_a); end
        n_checks++;
        if (get_ovr_cnt(0) != ovr0) begin
            n_fail++; $display("FAIL glitch_overrun: pulses got %0d want 0", get_ovr_cnt(0) - ovr0);
        end
        send_frame(0, 8'h5A, 8, 0, 1'b0, 1, 1'b1);
        wait_valid(0, ok);
        n_checks++;
        if (!ok || get_data(0) !== 9'h05A) begin
            n_fail++; $display("FAIL glitch_next: valid=%b data %h want 1/05a", ok, get_data(0));
        end
        n_checks++;
        if (get_flags(0) !== 4'b1000) begin
            n_fail++; $display("FAIL glitch_next_flags: got %b want 1000", get_flags(0));
        end
        accept(0);
    endtask

    task automatic test_frame_err;
        bit ok;
        int ovr0;
        ovr0 = get_ovr_cnt(0);
        send_frame(0, 8'h00, 8, 0, 1'b0, 1, 1'b0);
        hold_line(0, 1'b0, 20);
        hold_line(0, 1'b1, 2 * BIT_CLKS);
        wait_valid(0, ok);
        n_checks++;
        if (!ok || get_data(0) !== 9'h000) begin
            n_fail++; $display("FAIL ferr_data: valid=%b data %h want 1/000", ok, get_data(0));
        end
        n_checks++;
        if (get_flags(0) !== 4'b1010) begin
            n_fail++; $display("FAIL ferr_flags: got %b want 1010", get_flags(0));
        end
        accept(0);
        send_frame(0, 8'h3C, 8, 0, 1'b0, 1, 1'b1);
        wait_valid(0, ok);
        n_checks++;
        if (!ok || get_data(0) !== 9'h03C) begin
            n_fail++; $display("FAIL ferr_next_data: valid=%b data %h want 1/03c", ok, get_data(0));
        end
        n_checks++;
        if (get_flags(0) !== 4'b1000) begin
            n_fail++; $display("FAIL ferr_next_flags: got %b want 1000", get_flags(0));
        end
        n_checks++;
        if (get_ovr_cnt(0) != ovr0) begin
            n_fail++; $display("FAIL ferr_spurious: overrun pulses got %0d want 0", get_ovr_cnt(0) - ovr0);
        end
        accept(0);
    endtask

    task automatic test_back_to_back;
        int ovr0;
        ovr0 = get_ovr_cnt(0);
        send_frame(0, 8'h11, 8, 0, 1'b0, 1, 1'b1);
        send_frame(0, 8'h22, 8, 0, 1'b0, 1, 1'b1);
        repeat (12) @(negedge clk);
        n_checks++;
        if (get_ovr_cnt(0) - ovr0 != 1) begin
            n_fail++; $display("FAIL b2b_overrun: pulse cycles got %0d want 1", get_ovr_cnt(0) - ovr0);
        end
        n_checks++;
        if (vld_a !== 1'b1 || get_data(0) !== 9'h011) begin
            n_fail++; $display("FAIL b2b_held: valid=%b data %h want 1/011", vld_a, get_data(0));
        end
        accept(0);
        @(negedge clk);
        n_checks++;
        if (vld_a !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: valid got %b want 0", vld_a); end
    endtask

    task automatic test_parity;
        bit ok;
        bit p;
        int data;
        // Directed even-parity cases first, then random words and parity bits.
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      begin data = 8'h07; p = 1'b1; end
            else if (i == 1) begin data = 8'h07; p = 1'b0; end
            else             begin data = int'($urandom_range(0, 255)); p = bit'($urandom_range(0, 1)); end
            send_frame(1, data, 8, 2, p, 1, 1'b1);
            wait_valid(1, ok);
            n_checks++;
            if (!ok || get_data(1) !== 9'(data)) begin
                n_fail++; $display("FAIL par_data[%0d]: valid=%b data %h want 1/%h", i, ok, get_data(1), data);
            end
            n_checks++;
            if (get_flags(1) !== {1'b1, model_perr(2, data, 8, p), 2'b00}) begin
                n_fail++; $display("FAIL par_flags[%0d]: got %b want %b", i, get_flags(1),
                                   {1'b1, model_perr(2, data, 8, p), 2'b00});
            end
            accept(1);
        end
    endtask

    task automatic test_random_8n1;
        bit ok;
        int data;
        for (int i = 0; i < 5; i++) begin
            data = int'($urandom_range(0, 255));
            hold_line(0, 1'b1, int'($urandom_range(0, 5)));
            send_frame(0, data, 8, 0, 1'b0, 1, 1'b1);
            wait_valid(0, ok);
            n_checks++;
            if (!ok || get_data(0) !== 9'(data) || get_flags(0) !== 4'b1000) begin
                n_fail++; $display("FAIL rand8n1[%0d]: data %h flags %b want %h/1000", i, get_data(0), get_flags(0), data);
            end
            accept(0);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        send_frame(2, 7'h55, 7, 1, 1'b1, 2, 1'b1);
        wait_valid(2, ok);
        n_checks++;
        if (!ok || get_data(2) !== 9'h055) begin
            n_fail++; $display("FAIL rst_first_data: valid=%b data %h want 1/055", ok, get_data(2));
        end
        n_checks++;
        if (get_flags(2) !== {1'b1, model_perr(1, 7'h55, 7, 1'b1), 2'b00}) begin
            n_fail++; $display("FAIL rst_first_flags: got %b want 1000", get_flags(2));
        end
        accept(2);
        hold_line(2, 1'b0, BIT_CLKS);
        hold_line(2, 1'b1, BIT_CLKS);
        hold_line(2, 1'b0, 7);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (get_data(2) !== 9'h000 || get_flags(2) !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid: data %h flags %b want 000/0000", get_data(2), get_flags(2));
        end
        rxd_c = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_checks++;
        if (vld_c !== 1'b0 || ovr_cnt_c != 0) begin
            n_fail++; $display("FAIL rst_aborted: valid %b overruns %0d want 0/0", vld_c, ovr_cnt_c);
        end
        send_frame(2, 7'h2A, 7, 1, 1'b0, 2, 1'b1);
        wait_valid(2, ok);
        n_checks++;
        if (!ok || get_data(2) !== 9'h02A) begin
            n_fail++; $display("FAIL rst_third_data: valid=%b data %h want 1/02a", ok, get_data(2));
        end
        n_checks++;
        if (get_flags(2) !== {1'b1, model_perr(1, 7'h2A, 7, 1'b0), 2'b00}) begin
            n_fail++; $display("FAIL rst_third_flags: got %b want 1000", get_flags(2));
        end
        accept(2);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_frame_err;
        test_back_to_back;
        test_random_8n1;
        test_parity;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
